// File: rtl/div_issue_if.sv
// Bundled handshake signals between the execute stage, the divider and the writeback port.
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef INST_DIV
`define INST_DIV  3'b100
`define INST_DIVU 3'b101
`define INST_REM  3'b110
`define INST_REMU 3'b111
`endif

interface div_issue_if;
  // execute-stage request
  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      req_op_i;
  logic [`RegBus]  req_rs1_i;
  logic [`RegBus]  req_rs2_i;
  logic [4:0]      req_rd_i;
  logic            flush_i;
  // divider side
  logic [`RegBus]  div_dividend_o;
  logic [`RegBus]  div_divisor_o;
  logic [2:0]      div_op_o;
  logic            div_start_o;
  logic [`RegBus]  div_result_i;
  logic            div_valid_i;
  logic            div_ready_o;
  // register-file writeback
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [4:0]      wb_rd_o;
  logic [`RegBus]  wb_data_o;
  // status
  logic            busy_o;
  logic            timeout_o;

  // View taken by div_issue itself.
  modport slave (
    input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
    input  div_result_i, div_valid_i, wb_ready_i,
    output req_ready_o, div_dividend_o, div_divisor_o, div_op_o, div_start_o, div_ready_o,
    output wb_valid_o, wb_rd_o, wb_data_o, busy_o, timeout_o
  );

  // View taken by the surrounding pipeline / divider / register file.
  modport master (
    output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
    output div_result_i, div_valid_i, wb_ready_i,
    input  req_ready_o, div_dividend_o, div_divisor_o, div_op_o, div_start_o, div_ready_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, busy_o, timeout_o
  );
endinterface

// File: rtl/div_issue.sv
// Divide issue controller: accepts one divide op, drives the iterative divider, waits for the
// result with a timeout, and hands the result to the register-file writeback port.
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef INST_DIV
`define INST_DIV  3'b100
`define INST_DIVU 3'b101
`define INST_REM  3'b110
`define INST_REMU 3'b111
`endif

module div_issue #(
  parameter int unsigned TIMEOUT = 48
) (
  input logic        clk,
  input logic        rst,
  div_issue_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StAck, StWb, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_inc;
  logic            drain_q;
  logic [`RegBus]  dividend_q, divisor_q, result_q;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;

  logic op_is_div;
  logic accept;
  logic accept_issue;
  logic timeout_hit;

  // Request decode, saturating ISSUE-cycle counter and timeout detection.
  always_comb begin
    op_is_div    = bus.req_op_i inside {`INST_DIV, `INST_DIVU, `INST_REM, `INST_REMU};
    accept       = (state_q == StIdle) && bus.req_valid_i && op_is_div && !bus.flush_i;
    // rd=0 requests are consumed without ever touching the divider.
    accept_issue = accept && (bus.req_rd_i != 5'd0);
    cnt_inc      = (cnt_q == CntW'(TIMEOUT)) ? cnt_q : cnt_q + CntW'(1);
    // cnt_inc equals the 1-based index of the current ISSUE cycle.
    timeout_hit  = (state_q == StIssue) && (cnt_inc == CntW'(TIMEOUT));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush has priority over a same-cycle divider result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept_issue) state_d = StIssue;
      end
      StIssue: begin
        if (bus.flush_i)          state_d = StDrain;
        else if (bus.div_valid_i) state_d = StAck;
        else if (timeout_hit)     state_d = StDrain;
      end
      StAck: begin
        state_d = bus.flush_i ? StDrain : StWb;
      end
      StWb: begin
        if (bus.flush_i || bus.wb_ready_i) state_d = StIdle;
      end
      StDrain: begin
        if (drain_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand/result capture, cycle counter and two-cycle drain timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      drain_q    <= 1'b0;
    end else begin
      if (accept_issue) begin
        dividend_q <= bus.req_rs1_i;
        divisor_q  <= bus.req_rs2_i;
        op_q       <= bus.req_op_i;
        rd_q       <= bus.req_rd_i;
        cnt_q      <= '0;
      end else if (state_q == StIssue) begin
        cnt_q <= cnt_inc;
      end
      if ((state_q == StIssue) && bus.div_valid_i && !bus.flush_i) begin
        result_q <= bus.div_result_i;
      end
      drain_q <= (state_q == StDrain) && !drain_q;
    end
  end

  // Outputs; while rst is high everything shows reset values, even mid-operation.
  always_comb begin
    bus.req_ready_o    = 1'b0;
    bus.div_dividend_o = '0;
    bus.div_divisor_o  = '0;
    bus.div_op_o       = '0;
    bus.div_start_o    = 1'b0;
    bus.div_ready_o    = 1'b0;
    bus.wb_valid_o     = 1'b0;
    bus.wb_rd_o        = '0;
    bus.wb_data_o      = '0;
    bus.busy_o         = 1'b0;
    bus.timeout_o      = 1'b0;
    if (rst) begin
      bus.req_ready_o = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          bus.req_ready_o = op_is_div && !bus.flush_i;
        end
        StIssue: begin
          bus.busy_o         = 1'b1;
          bus.div_start_o    = 1'b1;
          bus.div_dividend_o = dividend_q;
          bus.div_divisor_o  = divisor_q;
          bus.div_op_o       = op_q;
          // Only pulse when the request is really abandoned.
          bus.timeout_o      = timeout_hit && !bus.flush_i && !bus.div_valid_i;
        end
        StAck: begin
          bus.busy_o         = 1'b1;
          bus.div_start_o    = 1'b1;
          bus.div_ready_o    = 1'b1;
          bus.div_dividend_o = dividend_q;
          bus.div_divisor_o  = divisor_q;
          bus.div_op_o       = op_q;
        end
        StWb: begin
          bus.busy_o     = 1'b1;
          bus.wb_valid_o = 1'b1;
          bus.wb_rd_o    = rd_q;
          bus.wb_data_o  = result_q;
        end
        StDrain: begin
          bus.busy_o      = 1'b1;
          bus.div_ready_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_issue.md
DIV_ISSUE -- requirements
Module: div_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 48, the maximum cycles in ISSUE before the request is abandoned.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid_i, input, 1, divide request from the execute stage.
REQ-005 SHALL have port req_ready_o, output, 1, request accepted on req_valid_i & req_ready_o.
REQ-006 SHALL have ports req_op_i (in, 3, `INST_DIV/DIVU/REM/REMU), req_rs1_i (in, `RegBus, dividend), req_rs2_i (in, `RegBus, divisor) and req_rd_i (in, 5, destination register).
REQ-007 SHALL have port flush_i, input, 1, pipeline flush that discards the in-flight request.
REQ-008 SHALL have ports div_dividend_o and div_divisor_o (out, `RegBus) and div_op_o (out, 3): operands and op to the divider, registered at accept.
REQ-009 SHALL have port div_start_o, output, 1, divider start, held high for the whole operation.
REQ-010 SHALL have ports div_result_i (in, `RegBus), div_valid_i (in, 1, result valid) and div_ready_o (out, 1, result accepted).
REQ-011 SHALL have ports wb_valid_o (out, 1), wb_ready_i (in, 1), wb_rd_o (out, 5) and wb_data_o (out, `RegBus): register-file writeback handshake.
REQ-012 SHALL have ports busy_o (out, 1, high in any non-IDLE state; pipeline stall) and timeout_o (out, 1, one-cycle pulse on abandon).

Function
REQ-013 SHALL implement the states IDLE, ISSUE, ACK, WB and DRAIN.
REQ-014 IDLE: req_ready_o=1; accept only when req_op_i is one of the four divide ops, otherwise req_ready_o=0.
REQ-015 IDLE accept with req_rd_i≠0: latch the operands, op and rd, clear the timeout counter, go to ISSUE.
REQ-016 IDLE accept with req_rd_i=0: no divider issue; go directly to IDLE with no writeback (one-cycle consume).
REQ-017 ISSUE: div_start_o=1, div_ready_o=0; the counter increments each cycle.
REQ-018 ISSUE, on div_valid_i=1: capture div_result_i into wb_data_o and go to ACK.
REQ-019 ACK: lasts exactly 1 cycle with div_start_o=1 and div_ready_o=1 (clears divider valid), then go to WB.
REQ-020 WB: div_start_o=0, wb_valid_o=1; rd and data stay stable until wb_ready_i=1; on handshake go to IDLE.
REQ-021 A new request SHALL NOT be accepted in the same cycle as the WB handshake; minimum request-to-request spacing is therefore the divider latency + 3 cycles.
REQ-022 Counter reaching TIMEOUT in ISSUE: pulse timeout_o for 1 cycle, go to DRAIN, no writeback.
REQ-023 flush_i=1 in ISSUE or ACK: go to DRAIN, no writeback; in WB: drop wb_valid_o next cycle and go to IDLE; in IDLE: suppress the accept.
REQ-024 DRAIN: div_start_o=0, div_ready_o=1 for exactly 2 cycles, then go to IDLE; any div_valid_i seen in DRAIN is ignored.
REQ-025 If flush_i and div_valid_i arrive in the same ISSUE cycle, flush SHALL win.
REQ-026 div_op_o and the operands SHALL stay stable from accept until leaving ISSUE/ACK, and SHALL be 0 in IDLE.
REQ-027 The counter SHALL be $clog2(TIMEOUT+1) bits and saturate; there is no wrap-around.

Reset
REQ-028 While rst=1, state SHALL be IDLE and all outputs 0 except req_ready_o=1, including a reset asserted mid-operation.
REQ-029 After rst deasserts, a request in the first cycle SHALL be acceptable.

Verification
REQ-030 Directed scenario: DIVU 100/7, rd=5, divider valid after 33 cycles, wb_ready_i=1 -> wb_rd_o=5, wb_data_o=14, one WB beat, div_ready_o high exactly 1 cycle.
REQ-031 Directed scenario: REM -7/2, wb_ready_i low for 4 cycles -> wb_data_o=0xFFFFFFFF held stable 5 cycles, then busy_o falls.
REQ-032 Directed scenario: DIV with rd=0 -> div_start_o never rises, wb_valid_o stays 0, req_ready_o returns to 1 the next cycle.
REQ-033 Directed scenario: flush_i at ISSUE cycle 10 -> div_start_o low within 1 cycle, DRAIN lasts 2 cycles, no writeback, next request accepted.
REQ-034 Directed scenario: divider never asserts valid, TIMEOUT=48 -> timeout_o pulses once on cycle 48 of ISSUE, then DRAIN and IDLE.
REQ-035 Directed scenario: rst at ISSUE cycle 5 -> next cycle all outputs at reset values and busy_o=0.
